// File: rtl/delay_timer_bank_if.sv
// delay_timer_bank_if: configuration write bus for the delay timer bank.
// The master drives one write per asserted wr_i cycle: the channel index,
// the new terminal count and the new mode bit.
interface delay_timer_bank_if #(
  parameter int SEL_W = 2,
  parameter int CNT_W = 21
);
  logic             wr_i;
  logic [SEL_W-1:0] wr_ch_i;
  logic [CNT_W-1:0] wr_tc_i;
  logic             wr_periodic_i;

  modport master (
    output wr_i,
    output wr_ch_i,
    output wr_tc_i,
    output wr_periodic_i
  );

  modport slave (
    input wr_i,
    input wr_ch_i,
    input wr_tc_i,
    input wr_periodic_i
  );
endinterface

// File: rtl/delay_timer_bank.sv
// delay_timer_bank: CH_N independent programmable delay timers that share one
// tick prescaler. Each channel counts ticks while enabled and pulses ready_o
// for one clock when its terminal count is reached. One channel is also
// mirrored, one clock later, onto ready_sel_o.
// Optional feature macro: DELAY_PERIODIC_EN adds a per-channel periodic mode.
// Without it every channel is one-shot and wr_periodic_i is ignored.
module delay_timer_bank #(
  parameter int CH_N       = 4,
  parameter int SEL_W      = 2,
  parameter int CNT_W      = 21,
  parameter int PRE_DIV    = 50,
  parameter int TC_DEFAULT = 10000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CH_N-1:0]         en_i,
  input  logic [SEL_W-1:0]        sel_i,
  delay_timer_bank_if.slave       cfg,
  output logic [CH_N-1:0]         ready_o,
  output logic [CH_N-1:0]         busy_o,
  output logic                    ready_sel_o
);

  localparam int PRE_W = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int SEL_N = 1 << SEL_W;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  logic [PRE_W-1:0] presc;
  logic             tick;
  logic [SEL_N-1:0] ready_ext;

  assign tick = (presc == PRE_W'(PRE_DIV - 1));

  // Free-running prescaler; tick marks the last cycle of each period.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  for (genvar k = 0; k < CH_N; k++) begin : g_ch
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] tc;
    logic             periodic;
    logic             wr_hit;
    logic             expire;
    logic             ready_r;
    logic             busy_r;

    assign wr_hit = cfg.wr_i && (cfg.wr_ch_i == SEL_W'(k));
    // Widened compare so tc = 0 or a tc lowered below cnt still expires.
    assign expire = ({1'b0, cnt} + (CNT_W + 1)'(1)) >= {1'b0, tc};

    // Terminal count register, rewritten by a config write to this channel.
    always_ff @(posedge clk) begin
      if (reset) begin
        tc <= CNT_W'(TC_DEFAULT);
      end else if (wr_hit) begin
        tc <= cfg.wr_tc_i;
      end
    end

`ifdef DELAY_PERIODIC_EN
    // Mode register: 1 reloads and keeps running after each expiry.
    always_ff @(posedge clk) begin
      if (reset) begin
        periodic <= 1'b0;
      end else if (wr_hit) begin
        periodic <= cfg.wr_periodic_i;
      end
    end
`else
    assign periodic = 1'b0;
`endif

    // Channel state machine with registered ready/busy outputs.
    always_ff @(posedge clk) begin
      if (reset) begin
        state   <= IDLE;
        cnt     <= '0;
        ready_r <= 1'b0;
        busy_r  <= 1'b0;
      end else begin
        ready_r <= 1'b0;
        if (!en_i[k]) begin
          state  <= IDLE;
          cnt    <= '0;
          busy_r <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              cnt <= '0;
              if (tc != '0) begin
                state  <= RUN;
                busy_r <= 1'b1;
              end
            end
            RUN: begin
              if (tick) begin
                if (expire) begin
                  ready_r <= 1'b1;
                  cnt     <= '0;
                  if (!periodic) begin
                    state  <= DONE;
                    busy_r <= 1'b0;
                  end
                end else begin
                  cnt <= cnt + 1'b1;
                end
              end
            end
            DONE: begin
              busy_r <= 1'b0;
            end
            default: begin
              state  <= IDLE;
              cnt    <= '0;
              busy_r <= 1'b0;
            end
          endcase
        end
      end
    end

    assign ready_o[k] = ready_r;
    assign busy_o[k]  = busy_r;
  end

`ifndef DELAY_PERIODIC_EN
  logic unused_wr_periodic;
  assign unused_wr_periodic = cfg.wr_periodic_i;
`endif

  // Zero-padded so any out-of-range select reads back as 0.
  assign ready_ext = SEL_N'(ready_o);

  // Legacy single-channel view of the selected ready pulse, one clock late.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_sel_o <= 1'b0;
    end else begin
      ready_sel_o <= ready_ext[sel_i];
    end
  end

endmodule

// File: doc/delay_timer_bank.md
# delay_timer_bank

Parametrised bank of CH_N independent programmable delay timers sharing one system clock and one internal microsecond-style tick prescaler. Each channel counts prescaled ticks while enabled and emits a one-clock `ready` pulse when its programmed terminal count is reached, in one-shot or periodic mode. A selected channel is also muxed onto a single registered `ready_sel_o` for legacy consumers. The block sits between the control FSMs that need fixed waits (debounce, power-up, scan intervals) and the system clock domain.

## Interface
- CH_N, 4: number of timer channels (1..16)
- SEL_W, 2: width of channel index ports; 2**SEL_W >= CH_N
- CNT_W, 21: counter / terminal-count width
- PRE_DIV, 50: clk cycles per tick (>= 1)
- TC_DEFAULT, 10000: reset value of every channel's terminal count

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en_i  in  CH_N  per-channel run enable (level)
- sel_i  in  SEL_W  channel routed to ready_sel_o
- wr_i  in  1  config write strobe
- wr_ch_i  in  SEL_W  channel addressed by write
- wr_tc_i  in  CNT_W  new terminal count
- wr_periodic_i  in  1  new mode bit (1 = periodic)
- ready_o  out  CH_N  per-channel one-clk expiry pulse
- busy_o  out  CH_N  channel in RUN state
- ready_sel_o  out  1  registered ready_o[sel_i]

## Operation
- Prescaler: free-running counter 0..PRE_DIV-1; `tick` = 1 in the cycle it equals PRE_DIV-1, then wraps to 0. PRE_DIV = 1 gives tick every cycle.
- Per-channel state machine, states IDLE, RUN, DONE:
  - any state, en_i[k] = 0: next IDLE, cnt = 0.
  - IDLE, en_i[k] = 1: next RUN, cnt = 0. tc = 0: stay IDLE (channel disabled).
  - RUN, counted cycle (en_i[k] = 1 and tick = 1): if cnt >= tc-1 -> ready_o[k] = 1 next cycle, cnt = 0, next DONE (one-shot) or stay RUN (periodic); else cnt += 1.
  - DONE: hold, ready_o[k] = 0, until en_i[k] drops.
- Compare is `>=`, not `==`: lowering tc below the current count fires at the next counted tick; no wrap-around at 2**CNT_W.
- Config write: when wr_i = 1 and wr_ch_i < CH_N, tc[wr_ch_i] and mode[wr_ch_i] update at the clock edge; wr_ch_i >= CH_N ignored. Write and counted tick in the same cycle: the compare uses the old tc.
- ready_sel_o = ready_o[sel_i] registered; 0 when sel_i >= CH_N.
- Reset: prescaler 0, all channels IDLE, cnt 0, tc = TC_DEFAULT, mode one-shot, ready_o = 0, busy_o = 0, ready_sel_o = 0.

## Timing
- All outputs registered; no combinational input-to-output paths.
- busy_o[k] high from the cycle after en_i[k] is sampled high until DONE or IDLE.
- en_i[k] rises with prescaler phase p: ready_o[k] pulses tc*PRE_DIV - p cycles after the rising edge is sampled (i.e. the cycle after the tc-th counted tick). The bound is (tc-1)*PRE_DIV+1 .. tc*PRE_DIV cycles.
- Periodic: successive ready_o[k] pulses exactly tc*PRE_DIV cycles apart.
- ready_sel_o lags ready_o[sel_i] by 1 clk.
- en_i[k] dropping in the same cycle as the expiring tick: no pulse; channel goes IDLE.
- Reset mid-count: all channels return to IDLE on the next edge; in-flight pulses are suppressed.

## Configuration
- DELAY_PERIODIC_EN defined: mode registers exist; periodic behaviour as above.
- Not defined: mode registers are removed; wr_periodic_i is ignored; every channel is one-shot (RUN -> DONE on expiry).

## Test plan
- Reset, PRE_DIV=50, en_i[0]=1 at tick phase 0, tc default 10000 -> single ready_o[0] pulse exactly 500000 cycles later; busy_o[0] drops the same cycle; no further pulses while en held.
- Write ch1 tc=3, periodic=1; en_i[1]=1 -> ready_o[1] pulses every 150 cycles; with the macro undefined, exactly one pulse.
- ch2 running with cnt=7, write tc=4 -> ready_o[2] at the next counted tick.
- en_i[3] deasserted in the tick cycle of expiry -> no pulse; re-enable restarts the full tc count.
- sel_i=1 with ch1 firing -> ready_sel_o high 1 cycle after ready_o[1]; sel_i=3 with CH_N=3 -> ready_sel_o stays 0.
- Write tc=0 to ch0, enable -> busy_o[0]=0, no pulse; reset asserted mid-count on all channels -> all outputs 0 the next cycle.
